if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rstn, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port o_imem_req, output, 1, instruction memory request.
REQ-004 SHALL have port o_imem_addr, output, 32, word-aligned fetch address.
REQ-005 SHALL have port i_imem_ack, input, 1, memory ack; i_imem_rdata is valid in the ack cycle.
REQ-006 SHALL have port i_imem_rdata, input, 32, fetched instruction.
REQ-007 SHALL have port i_redirect, input, 1, taken branch from the MEM stage (Branch & zero).
REQ-008 SHALL have port i_redirect_pc, input, 32, branch target.
REQ-009 SHALL have port i_stall, input, 1, IF/ID hold from the hazard logic.
REQ-010 SHALL have port o_valid, output, 1, head instruction present for IF/ID.
REQ-011 SHALL have port o_instr, output, 32, head instruction.
REQ-012 SHALL have port o_pcplus4, output, 32, head instruction address + 4.
REQ-013 SHALL have port o_fetch_count, output, 32, count of instructions delivered to IF/ID.

Function
REQ-014 SHALL hold a PC register and a 2-entry FIFO queue of {instr, pcplus4}; o_valid = queue not empty; o_instr/o_pcplus4 = head entry.
REQ-015 SHALL pop the head on every cycle with o_valid=1 and i_stall=0.
REQ-016 SHALL implement the FSM states IDLE, REQ and DROP, with o_imem_req = (state != IDLE) and o_imem_addr = PC.
REQ-017 IDLE: on i_redirect, PC <= {i_redirect_pc[31:2],2'b00}, flush the queue, stay in IDLE; otherwise go to REQ when post-pop occupancy < 2.
REQ-018 REQ: hold o_imem_addr stable until ack; on an ack without redirect, push {rdata, PC+4} and set PC <= PC+4, then stay in REQ if post-push/pop occupancy < 2, otherwise go to IDLE.
REQ-019 REQ with i_redirect and same-cycle ack: discard the data, PC <= target, flush, go to IDLE.
REQ-020 REQ with i_redirect and no ack: flush, save the target, go to DROP; req stays high with the old address.
REQ-021 DROP: on ack, discard the data, PC <= saved target, go to IDLE; a new i_redirect in DROP overwrites the saved target and flushes again.
REQ-022 SHALL give i_redirect priority over push and pop in the same cycle; o_valid=0 in the cycle after any redirect.
REQ-023 SHALL allow a simultaneous push and pop at occupancy 1 (occupancy stays 1), and SHALL never push while full.
REQ-024 SHALL ignore i_imem_ack when the FSM is in IDLE.
REQ-025 PC arithmetic SHALL be modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-026 Latency with zero-wait memory: the ack edge pushes, and o_valid=1 in the following cycle; throughput of one instruction per cycle while i_stall=0.

Reset
REQ-027 SHALL, while i_rstn=0, force PC=0x00000000, state IDLE and an empty queue, giving o_valid=0, o_imem_req=0, o_imem_addr=0, o_instr=0, o_pcplus4=0 and o_fetch_count=0.
REQ-028 Reset mid-request SHALL abandon the outstanding fetch; after release, fetching restarts at 0x00000000.

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined, o_fetch_count SHALL increment by 1 per pop and wrap at 2^32.
REQ-030 Without FETCH_PERF_CNT_EN, o_fetch_count SHALL be constant 0 and no counter flop SHALL be built.

Verification
REQ-031 Reset release, zero-wait memory returning the address as data, i_stall=0 -> o_valid from cycle 3; o_instr 0x0,0x4,0x8 on consecutive cycles; o_pcplus4 = o_instr+4.
REQ-032 i_stall=1 for 5 cycles -> queue fills to 2, o_imem_req=0, o_instr holds; on release, two buffered entries then fetch resumes with no loss or duplication.
REQ-033 Memory with 3-cycle ack latency, i_redirect to 0x100 one cycle after req rises -> req held at the old address until ack, data dropped, next request at 0x100, first o_instr is the word at 0x100.
REQ-034 i_redirect to 0x203 coincident with an ack -> ack data discarded, o_valid=0 next cycle, next o_imem_addr=0x200.
REQ-035 PC forced near 0xFFFFFFF8 via redirect -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; o_pcplus4 of the 0xFFFFFFFC fetch is 0x00000000.
REQ-036 FETCH_PERF_CNT_EN defined, 10 pops with 2 stall cycles interleaved -> o_fetch_count=10; macro undefined -> o_fetch_count remains 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC register, IDLE/REQ/DROP memory request FSM and a 2-entry IF/ID queue.
// Optional: define FETCH_PERF_CNT_EN to build the delivered-instruction counter behind o_fetch_count.
module if_fetch_unit (
    input  logic        i_clk,
    input  logic        i_rstn,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic [31:0] o_fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] saved_pc;
    logic [1:0]  occ;
    logic [31:0] head_instr, head_pc4, tail_instr, tail_pc4;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        pop;
    logic        push;
    logic [1:0]  occ_pop;
    logic [1:0]  occ_next;

    // A redirect wins over both queue operations, so neither pop nor push fires in that cycle.
    always_comb begin
        redirect_target = i_redirect_pc & ~32'd3;
        pc_plus4        = pc + 32'd4;
        pop             = (occ != 2'd0) && !i_stall && !i_redirect;
        push            = (state == REQ) && i_imem_ack && !i_redirect;
        occ_pop         = occ - {1'b0, pop};
        occ_next        = occ_pop + {1'b0, push};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            occ        <= 2'd0;
            head_instr <= 32'd0;
            head_pc4   <= 32'd0;
            tail_instr <= 32'd0;
            tail_pc4   <= 32'd0;
        end else if (i_redirect) begin
            occ <= 2'd0;
        end else begin
            occ <= occ_next;
            if (push && occ_pop == 2'd0) begin
                head_instr <= i_imem_rdata;
                head_pc4   <= pc_plus4;
            end else if (pop) begin
                head_instr <= tail_instr;
                head_pc4   <= tail_pc4;
            end
            if (push && occ_pop == 2'd1) begin
                tail_instr <= i_imem_rdata;
                tail_pc4   <= pc_plus4;
            end
        end
    end

    // In DROP the old address stays on the bus until its ack retires the abandoned fetch.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            pc       <= 32'd0;
            saved_pc <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_redirect) begin
                        pc <= redirect_target;
                    end else if (occ_pop < 2'd2) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (i_redirect) begin
                        if (i_imem_ack) begin
                            pc    <= redirect_target;
                            state <= IDLE;
                        end else begin
                            saved_pc <= redirect_target;
                            state    <= DROP;
                        end
                    end else if (i_imem_ack) begin
                        pc <= pc_plus4;
                        if (occ_next == 2'd2) begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (i_imem_ack) begin
                        pc    <= i_redirect ? redirect_target : saved_pc;
                        state <= IDLE;
                    end else if (i_redirect) begin
                        saved_pc <= redirect_target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_imem_req  = (state != IDLE);
    assign o_imem_addr = pc;
    assign o_valid     = (occ != 2'd0);
    assign o_instr     = head_instr;
    assign o_pcplus4   = head_pc4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fetch_count <= 32'd0;
        end else if (pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign o_fetch_count = fetch_count;
`else
    assign o_fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: queue-based reference model plus directed scenarios.
// Honours FETCH_PERF_CNT_EN the same way the design does.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;
    int mem_wait = 0;
    int wait_cnt = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    // Reference model: the IF/ID queue plus "a fetch is outstanding" and "its data is unwanted".
    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_target;
    logic [31:0] m_cnt;
    bit          m_busy;
    bit          m_drop;

    if_fetch_unit dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (mem_ack),
        .i_imem_rdata  (mem_rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_stall       (stall),
        .o_valid       (valid),
        .o_instr       (instr),
        .o_pcplus4     (pcplus4),
        .o_fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc     = 32'd0;
        m_target = 32'd0;
        m_cnt    = 32'd0;
        m_busy   = 1'b0;
        m_drop   = 1'b0;
    endtask

    task automatic model_step();
        bit          do_pop;
        logic [31:0] tgt;
        entry_t      e;
        if (!rstn) begin
            model_reset();
            return;
        end
        tgt    = {redirect_pc[31:2], 2'b00};
        do_pop = (m_q.size() > 0) && !stall && !redirect;
        if (redirect) begin
            m_q.delete();
            if (!m_busy) begin
                m_pc = tgt;
            end else if (mem_ack) begin
                m_pc   = tgt;
                m_busy = 1'b0;
                m_drop = 1'b0;
            end else begin
                m_target = tgt;
                m_drop   = 1'b1;
            end
        end else begin
            if (do_pop) begin
                void'(m_q.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (!m_busy) begin
                if (m_q.size() < 2) m_busy = 1'b1;
            end else if (mem_ack) begin
                if (m_drop) begin
                    m_pc   = m_target;
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    e.instr = mem_rdata;
                    e.pc4   = m_pc + 32'd4;
                    m_q.push_back(e);
                    m_pc = m_pc + 32'd4;
                    if (m_q.size() == 2) m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
        chk("imem_addr", imem_addr, m_pc);
        chk("valid", {31'd0, valid}, {31'd0, (m_q.size() > 0)});
        if (m_q.size() > 0) begin
            chk("instr", instr, m_q[0].instr);
            chk("pcplus4", pcplus4, m_q[0].pc4);
        end
        if (!rstn) begin
            chk("instr_rst", instr, 32'd0);
            chk("pcplus4_rst", pcplus4, 32'd0);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_cnt);
`else
        chk("fetch_count", fetch_count, 32'd0);
`endif
    endtask

    // Called at a falling edge: drive hazard inputs and the memory's reply, clock once, then compare.
    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        if (imem_req) begin
            if (wait_cnt >= mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = imem_addr;
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            wait_cnt  = 0;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic do_reset(input int cycles);
        rstn     = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        mem_ack  = 1'b0;
        wait_cnt = 0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            checkOutput();
        end
        rstn = 1'b1;
    endtask

    task automatic run_until_valid(input int limit);
        int k = 0;
        while (!valid && k < limit) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            k++;
        end
        chk("valid_timeout", {31'd0, valid}, 32'd1);
    endtask

    initial begin
        rstn        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        model_reset();
        @(negedge clk);
        do_reset(2);

        // Zero-wait streaming, two stall cycles, then a long stall to freeze the counter.
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(c == 5 || c == 6 || c >= 15, 1'b0, 32'd0);
            if (c == 2) chk("lit_instr0", instr, 32'h0);
            if (c == 3) begin
                chk("lit_instr4", instr, 32'h4);
                chk("lit_pc4_8", pcplus4, 32'h8);
            end
            if (c == 4) chk("lit_instr8", instr, 32'h8);
            if (c == 6) begin
                chk("lit_full_req", {31'd0, imem_req}, 32'd0);
                chk("lit_full_valid", {31'd0, valid}, 32'd1);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("lit_count10", fetch_count, 32'd10);
`else
        chk("lit_count0", fetch_count, 32'd0);
`endif

        // Long stall with a full queue, then release: buffered entries first, no gap.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'd0);
        chk("lit_stall_req", {31'd0, imem_req}, 32'd0);
        chk("lit_stall_head", instr, 32'h28);
        applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_rel1", instr, 32'h2C);
        applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_rel2", instr, 32'h30);
        applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_rel3", instr, 32'h34);

        // Redirect while a slow fetch is outstanding.
        applyStimulus(1'b0, 1'b1, 32'h40);
        chk("lit_redir_valid", {31'd0, valid}, 32'd0);
        mem_wait = 2;
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h100);
        chk("lit_drop_req", {31'd0, imem_req}, 32'd1);
        chk("lit_drop_addr", imem_addr, 32'h40);
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_after_drop_addr", imem_addr, 32'h100);
        run_until_valid(20);
        chk("lit_first_0x100", instr, 32'h100);

        // Redirect to an unaligned target coincident with an ack.
        mem_wait = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_pre_ack_req", {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h203);
        chk("lit_ackredir_valid", {31'd0, valid}, 32'd0);
        chk("lit_ackredir_addr", imem_addr, 32'h200);
        applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_next_req", {31'd0, imem_req}, 32'd1);
        chk("lit_next_addr", imem_addr, 32'h200);

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            if (c == 2) begin
                chk("lit_wrap_i0", instr, 32'hFFFF_FFF8);
                chk("lit_wrap_p0", pcplus4, 32'hFFFF_FFFC);
            end
            if (c == 3) begin
                chk("lit_wrap_i1", instr, 32'hFFFF_FFFC);
                chk("lit_wrap_p1", pcplus4, 32'h0);
            end
            if (c == 4) begin
                chk("lit_wrap_i2", instr, 32'h0);
                chk("lit_wrap_p2", pcplus4, 32'h4);
            end
        end

        // Reset in the middle of an outstanding request.
        applyStimulus(1'b0, 1'b1, 32'h500);
        mem_wait = 3;
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_midreq_addr", imem_addr, 32'h500);
        do_reset(2);
        applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_restart_req", {31'd0, imem_req}, 32'd1);
        chk("lit_restart_addr", imem_addr, 32'h0);

        // Second redirect while dropping overwrites the saved target.
        mem_wait = 2;
        applyStimulus(1'b0, 1'b1, 32'h300);
        applyStimulus(1'b0, 1'b1, 32'h406);
        applyStimulus(1'b0, 1'b0, 32'd0);
        chk("lit_overwrite_addr", imem_addr, 32'h404);
        run_until_valid(20);
        chk("lit_overwrite_instr", instr, 32'h404);

        // Mixed stalls, redirects and memory latencies, checked against the model only.
        for (int i = 0; i < 60; i++) begin
            mem_wait = i % 3;
            applyStimulus((i % 4 == 1) || (i % 7 == 3), (i % 13 == 9),
                          32'h1000 + 32'(i * 36) + 32'(i % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
